// File: rtl/tick_rate_controller_pkg.sv
// rtl/tick_rate_controller_pkg.sv - shared mode encodings and default timing constants
package tick_rate_controller_pkg;

   typedef enum logic [1:0] {
      MODE_STOPPED = 2'b00,
      MODE_SLOW    = 2'b01,
      MODE_FAST    = 2'b10
   } mode_e;

   localparam int unsigned DEF_SLOW_DIV     = 2_500_000;
   localparam int unsigned DEF_FAST_DIV     = 1_250_000;
   localparam int unsigned DEF_DEBOUNCE_CYC = 200_000;
   localparam int unsigned DEF_CNT_W        = 32;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_rate_controller_key_debounce.sv
// rtl/tick_rate_controller_key_debounce.sv - 2-FF sync, hold-time debounce, press pulse
module key_debounce
   import tick_rate_controller_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clock_i,
   input  logic reset_n_i,
   input  logic key_n_i,
   output logic press_o
);

   localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYC);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // Count only while the synced key disagrees with the accepted level; any agreement restarts it.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign press_o = level_q & ~level_d;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/tick_rate_controller.sv
// rtl/tick_rate_controller.sv - run/stop/speed FSM producing registered tick enables
module tick_rate_controller
   import tick_rate_controller_pkg::*;
#(
   parameter int unsigned SLOW_DIV     = DEF_SLOW_DIV,
   parameter int unsigned FAST_DIV     = DEF_FAST_DIV,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       key_run_n,
   input  logic       key_fast_n,
   output logic       tick,
   output logic       led,
   output logic [1:0] mode,
   output logic       running
);

   localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

   mode_e            state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, div_last;
   logic             tick_q, tick_d;
   logic             led_q, led_d;
   logic             run_ev, fast_ev, step;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_run (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .key_n_i   (key_run_n),
      .press_o   (run_ev)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_fast (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .key_n_i   (key_fast_n),
      .press_o   (fast_ev)
   );

   // Run press takes priority; a fast press in the same cycle is dropped.
   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      case (state_q)
         MODE_STOPPED: begin
            if (run_ev)       state_d = MODE_SLOW;
            else if (fast_ev) step    = 1'b1;
         end
         MODE_SLOW: begin
            if (run_ev)       state_d = MODE_STOPPED;
            else if (fast_ev) state_d = MODE_FAST;
         end
         MODE_FAST: begin
            if (run_ev)       state_d = MODE_STOPPED;
            else if (fast_ev) state_d = MODE_SLOW;
         end
         default: state_d = MODE_STOPPED;
      endcase
   end

   // A state change restarts the divider and swallows any tick due in that cycle.
   always_comb begin
      div_last = (state_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;
      cnt_d    = '0;
      tick_d   = 1'b0;
      if (state_d != state_q) begin
         tick_d = 1'b0;
      end else if (state_q == MODE_STOPPED) begin
         tick_d = step;
      end else if (cnt_q == div_last) begin
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      led_d = led_q ^ tick_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MODE_STOPPED;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         led_q   <= led_d;
      end
   end

   assign tick    = tick_q;
   assign led     = led_q;
   assign mode    = state_q;
   assign running = (state_q != MODE_STOPPED);

endmodule
